vga_timing_gen: RTL and testbench

- Produces the scan coordinates and sync signals that drive the display path.
- Its `x_o`/`y_o` outputs feed the game-window region checker and all downstream draw blocks.
- Runs on the 100 MHz board clock and divides it to a pixel-enable.
- Standard 640x480@60 timing: 800 clocks/line, 525 lines/frame.

---
 rtl/vga_timing_gen.sv | 104 ++++++++++
 tb/tb_vga_timing_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA scan timing: pixel-enable divider, x/y scan counters and
// registered sync, visible-area and frame-start decode.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       pix_tick_o,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       video_on_o,
    output logic       frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_LO   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_HI   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] X_VIS   = 10'(H_ACTIVE);
    localparam logic [9:0] Y_VIS   = 10'(V_ACTIVE);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             von_q, von_d;
    logic             fs_q, fs_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // Tick is registered so it reads 0 in the reset cycle even when CLK_DIV=1
        tick_d = (div_d == DIV_LAST);
        x_d    = x_q;
        y_d    = y_q;
        fs_d   = 1'b0;
        if (tick_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        // Decode from next-state counters so outputs line up with x_o/y_o
        hs_d  = !((x_d >= HS_LO) && (x_d <= HS_HI));
        vs_d  = !((y_d >= VS_LO) && (y_d <= VS_HI));
        von_d = (x_d < X_VIS) && (y_d < Y_VIS);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            von_q  <= 1'b1;
            fs_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            von_q  <= von_d;
            fs_q   <= fs_d;
        end
    end

    assign pix_tick_o    = tick_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign video_on_o    = von_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, scaled-down and CLK_DIV=1 builds
// compared against an arithmetic scan-position model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fs;
    } outs_t;

    typedef struct {
        logic  rst;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_std = 1'b1;
    logic rst_sml = 1'b1;
    logic rst_one = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    int c_std, c_sml, c_one;

    logic       t_s, hs_s, vs_s, von_s, fs_s;
    logic [9:0] x_s, y_s;
    logic       t_m, hs_m, vs_m, von_m, fs_m;
    logic [9:0] x_m, y_m;
    logic       t_o, hs_o, vs_o, von_o, fs_o;
    logic [9:0] x_o, y_o;

    outs_t o_std, o_sml, o_one;
    assign o_std = {t_s, x_s, y_s, hs_s, vs_s, von_s, fs_s};
    assign o_sml = {t_m, x_m, y_m, hs_m, vs_m, von_m, fs_m};
    assign o_one = {t_o, x_o, y_o, hs_o, vs_o, von_o, fs_o};

    vga_timing_gen u_std (
        .clk_i(clk), .rst_i(rst_std), .pix_tick_o(t_s),
        .x_o(x_s), .y_o(y_s), .hsync_o(hs_s), .vsync_o(vs_s),
        .video_on_o(von_s), .frame_start_o(fs_s)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_sml (
        .clk_i(clk), .rst_i(rst_sml), .pix_tick_o(t_m),
        .x_o(x_m), .y_o(y_m), .hsync_o(hs_m), .vsync_o(vs_m),
        .video_on_o(von_m), .frame_start_o(fs_m)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_one (
        .clk_i(clk), .rst_i(rst_one), .pix_tick_o(t_o),
        .x_o(x_o), .y_o(y_o), .hsync_o(hs_o), .vsync_o(vs_o),
        .video_on_o(von_o), .frame_start_o(fs_o)
    );

    // Clocks elapsed since the reset edge (0 = first cycle after it)
    always @(posedge clk) begin
        c_std <= rst_std ? 0 : c_std + 1;
        c_sml <= rst_sml ? 0 : c_sml + 1;
        c_one <= rst_one ? 0 : c_one + 1;
    end

    function automatic int pcnt(int c, int n);
        if (n == 1) return (c == 0) ? 0 : c - 1;
        return c / n;
    endfunction

    function automatic logic tick_at(int c, int n);
        if (n == 1) return c >= 1;
        return (c % n) == n - 1;
    endfunction

    function automatic outs_t model(int c, int n,
        int ha, int hf, int hw, int hb,
        int va, int vf, int vw, int vb);
        outs_t m;
        int ht, vt, p, x, y;
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        p  = pcnt(c, n);
        x  = p % ht;
        y  = (p / ht) % vt;
        m.tick = tick_at(c, n);
        m.x    = 10'(x);
        m.y    = 10'(y);
        m.hs   = !(x >= ha + hf && x < ha + hf + hw);
        m.vs   = !(y >= va + vf && y < va + vf + vw);
        m.von  = (x < ha) && (y < va);
        m.fs   = (c >= 1) && tick_at(c - 1, n)
                 && (p % (ht * vt) == 0);
        return m;
    endfunction

    function automatic outs_t m_std(int c);
        return model(c, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic outs_t m_sml(int c);
        return model(c, 3, 20, 4, 6, 5, 12, 2, 2, 3);
    endfunction

    function automatic outs_t m_one(int c);
        return model(c, 1, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic outs_t rv(logic tk, int x);
        outs_t m;
        m.tick = tk;
        m.x    = 10'(x);
        m.y    = '0;
        m.hs   = 1'b1;
        m.vs   = 1'b1;
        m.von  = 1'b1;
        m.fs   = 1'b0;
        return m;
    endfunction

    task automatic chk(string nm, outs_t a, outs_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got t%0b x%0d y%0d hs%0b vs%0b v%0b f%0b want t%0b x%0d y%0d hs%0b vs%0b v%0b f%0b",
                nm, a.tick, a.x, a.y, a.hs, a.vs, a.von, a.fs,
                e.tick, e.x, e.y, e.hs, e.vs, e.von, e.fs);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        n_tests++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    vec_t tbl[9];

    initial begin
        logic pv, reg_in;
        int fall_x, hs_clk, hs_first, hs_last, wraps, n;
        int fs_cnt, fs_c0, fs_c1, mism, bad_tick;
        int run, max_run, runs, c_x1, c_x1y1;
        bit found;

        tbl[0] = '{1'b1, rv(1'b0, 0)};
        tbl[1] = '{1'b0, rv(1'b0, 0)};
        tbl[2] = '{1'b0, rv(1'b0, 0)};
        tbl[3] = '{1'b0, rv(1'b1, 0)};
        tbl[4] = '{1'b0, rv(1'b0, 1)};
        tbl[5] = '{1'b0, rv(1'b0, 1)};
        tbl[6] = '{1'b0, rv(1'b0, 1)};
        tbl[7] = '{1'b0, rv(1'b1, 1)};
        tbl[8] = '{1'b0, rv(1'b0, 2)};

        step();
        step();

        // Reset release and first pixel ticks
        foreach (tbl[i]) begin
            rst_std = tbl[i].rst;
            step();
            chk($sformatf("vec%0d", i), o_std, tbl[i].exp);
        end

        // One full line plus wrap into line 1
        pv = von_s;
        fall_x = -1; hs_clk = 0; hs_first = -1; hs_last = -1;
        wraps = 0;
        for (int i = 0; i < 3300; i++) begin
            logic [9:0] px;
            px = x_s;
            step();
            chk("std_model", o_std, m_std(c_std));
            if (pv && !von_s && fall_x < 0) fall_x = int'(x_s);
            pv = von_s;
            if (!hs_s) begin
                hs_clk++;
                if (hs_first < 0) hs_first = int'(x_s);
                hs_last = int'(x_s);
            end
            if (px == 10'd799 && x_s != 10'd799) begin
                wraps++;
                chk_int("wrap_x", int'(x_s), 0);
                chk_int("wrap_y", int'(y_s), 1);
            end
        end
        chk_int("von_fall_x", fall_x, 640);
        chk_int("hs_low_clks", hs_clk, 384);
        chk_int("hs_first_x", hs_first, 656);
        chk_int("hs_last_x", hs_last, 751);
        chk_int("line_wraps", wraps, 1);

        // Reset in the middle of a line
        found = 0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (x_s == 10'd300 && y_s == 10'd1) found = 1;
            else step();
        end
        chk_int("reach_300_1", int'(found), 1);
        rst_std = 1'b1;
        step();
        rst_std = 1'b0;
        chk("mid_rst", o_std, rv(1'b0, 0));
        n = 1;
        while (!t_s && n < 10) begin
            step();
            n++;
        end
        chk_int("first_tick_clk", n, 4);

        // Scaled build: two frames free-running
        rst_sml = 1'b0;
        fs_cnt = 0; fs_c0 = 0; fs_c1 = 0; mism = 0;
        for (int i = 0; i < 2 * 1995 + 100; i++) begin
            step();
            chk("sml_model", o_sml, m_sml(c_sml));
            if (fs_m) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_c0 = c_sml;
                if (fs_cnt == 2) fs_c1 = c_sml;
            end
            reg_in = (x_m > 0) && (x_m < 20)
                     && (y_m > 0) && (y_m < 12);
            if (fs_cnt == 1 && t_m && reg_in != von_m) mism++;
        end
        chk_int("fs_pulses", fs_cnt, 2);
        chk_int("frame_period", fs_c1 - fs_c0, 1995);
        chk_int("win_mismatch", mism, 20 + 12 - 1);

        // Scaled build: random resets
        for (int i = 0; i < 3000; i++) begin
            rst_sml = ($urandom_range(0, 299) == 0);
            step();
            chk("sml_rand", o_sml, m_sml(c_sml));
        end
        rst_sml = 1'b0;

        // CLK_DIV=1 build
        rst_one = 1'b0;
        bad_tick = 0; run = 0; max_run = 0; runs = 0;
        c_x1 = -1; c_x1y1 = -1;
        for (int i = 0; i < 1700; i++) begin
            step();
            chk("one_model", o_one, m_one(c_one));
            if (c_one >= 1 && !t_o) bad_tick++;
            if (!hs_o) run++;
            else if (run > 0) begin
                runs++;
                if (run > max_run) max_run = run;
                run = 0;
            end
            if (x_o == 10'd1 && y_o == 10'd0 && c_x1 < 0)
                c_x1 = c_one;
            if (x_o == 10'd1 && y_o == 10'd1 && c_x1y1 < 0)
                c_x1y1 = c_one;
        end
        chk_int("one_no_tick", bad_tick, 0);
        chk_int("one_hs_run", max_run, 96);
        chk_int("one_hs_runs", runs, 2);
        chk_int("one_line_clks", c_x1y1 - c_x1, 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
